multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, using the codebase port names clk and reset.
REQ-002 Ports (name direction width meaning), one per line:
- clk in 1 rising-edge clock
- reset in 1 synchronous active-high reset
- op in 7 instr[6:0]
- funct3 in 3 instr[14:12]
- funct7b5 in 1 instr[30]
- zero in 1 ALU zero flag
- mem_ready in 1 memory completes access this cycle
- pc_write out 1 PC register load
- adr_src out 1 memory address: 0=pc, 1=alu_out
- ir_write out 1 latch instr and old_pc
- mem_write out 1 memory write strobe
- reg_write out 1 register file write
- result_src out 2 result mux: 00=alu_out, 01=data, 10=alu_result
- alu_src_a out 2 00=pc, 01=old_pc, 10=rd1, 11=zero
- alu_src_b out 2 00=rd2, 01=imm_ext, 10=constant 4
- imm_src out 3 000=I, 001=S, 010=B, 011=J, 100=U
- alu_control out 4 ALU operation
- illegal_instr out 1 unsupported opcode pulse
- instr_done out 1 last cycle of an instruction

Function
REQ-003 alu_control encoding SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
REQ-004 imm_src SHALL decode combinationally from op in every state: load/jalr/OP-IMM=I, store=S, branch=B, jal=J, lui/auipc=U, otherwise 000.
REQ-005 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC.
REQ-006 Outputs SHALL be combinational from state, op, funct3, funct7b5, zero and mem_ready; any output not listed for a state SHALL be 0.
REQ-007 FETCH: adr_src=0, src_a=00, src_b=10, ADD, result_src=10, ir_write=pc_write=mem_ready; stay in FETCH while mem_ready=0, otherwise go to DECODE.
REQ-008 DECODE: src_a=01, src_b=01, ADD; next state by op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, 0010111->AUIPC; any other op->FETCH with illegal_instr=1 and instr_done=1 this cycle.
REQ-009 MEMADR: src_a=10, src_b=01, ADD; next MEMREAD if op=0000011, else MEMWRITE.
REQ-010 MEMREAD: adr_src=1; hold while mem_ready=0, otherwise go to MEMWB. MEMWB: result_src=01, reg_write=1, instr_done=1, then FETCH.
REQ-011 MEMWRITE: adr_src=1, mem_write=1 held until mem_ready=1; in that cycle instr_done=1 and next state is FETCH.
REQ-012 EXECUTER: src_a=10, src_b=00, ALU op from funct3/funct7b5 (add/sub via funct7b5, sll, slt, sltu, xor, srl/sra, or, and); next ALUWB.
REQ-013 EXECUTEI: as EXECUTER but src_b=01, and funct7b5 SHALL select SUB never, SRA only when funct3=101; next ALUWB.
REQ-014 ALUWB: result_src=00, reg_write=1, instr_done=1; next FETCH.
REQ-015 BRANCH: src_a=10, src_b=00, SUB, result_src=00; pc_write=zero when funct3=000, pc_write=!zero when funct3=001, 0 for other funct3; instr_done=1; next FETCH.
REQ-016 JALR: src_a=10, src_b=01, ADD (target into alu_out); next JAL.
REQ-017 JAL: src_a=01, src_b=10, ADD, result_src=00, pc_write=1; next ALUWB, which writes old_pc+4 to rd.
REQ-018 LUI: src_a=11, src_b=01, ADD. AUIPC: src_a=01, src_b=01, ADD. Both go next to ALUWB.
REQ-019 Per-instruction latency with mem_ready=1: lw 5, sw 4, R/I/lui/auipc 4, branch 3, jal 4, jalr 5 cycles; each cycle of mem_ready=0 adds one cycle.

Reset
REQ-020 While reset=1, pc_write, ir_write, mem_write, reg_write, illegal_instr and instr_done SHALL be 0, and the state SHALL load FETCH at the clock edge.
REQ-021 Reset asserted mid-instruction (including a mem_ready stall) SHALL abandon the instruction; FETCH SHALL be entered on the next edge.

Structure
REQ-022 Opcode constants, alu_control codes, imm_src codes and state encodings SHALL reside in a shared package.
REQ-023 ALU function decode SHALL be one sub-module, alu_decoder (inputs: alu_op class, funct3, funct7b5, op[5]; output: alu_control).

Verification
REQ-024 Reset asserted for 2 cycles, then released with mem_ready=1 -> first cycle in FETCH with ir_write=pc_write=1; next cycle DECODE.
REQ-025 Sequence addi, add, lw, sw with mem_ready=1 -> state traces FETCH,DECODE,EXECUTEI,ALUWB / ...EXECUTER,ALUWB / ...MEMADR,MEMREAD,MEMWB / ...MEMADR,MEMWRITE; instr_done once per instruction.
REQ-026 beq (funct3=000) with zero=1 -> pc_write=1 in BRANCH; bne (funct3=001) with zero=1 -> pc_write=0.
REQ-027 lw with mem_ready held low for 3 cycles in MEMREAD -> adr_src=1 held; MEMWB entered only after mem_ready=1; reg_write pulses for 1 cycle.
REQ-028 jalr -> JALR, JAL (pc_write=1, result_src=00), then ALUWB (reg_write=1); total 5 cycles.
REQ-029 op=1111111 -> illegal_instr=1 for one DECODE cycle, then FETCH; reset asserted during a MEMWRITE stall -> mem_write=0 immediately and FETCH on the next edge.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, ALU codes,
// immediate formats, FSM states and the coarse ALU-op class.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
        S_LUI, S_AUIPC
    } state_e;

    // ADD/SUB are forced by the FSM; FUNCT defers to funct3/funct7b5.
    typedef enum logic [1:0] {
        ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
    } alu_op_e;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU function decode: maps the FSM's ALU-op class plus instruction fields
// onto the 4-bit alu_control code.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [3:0] alu_control
);

    // op5 separates R-type (may SUB) from OP-IMM (never SUB; SRA still via funct7b5)
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM. Outputs are combinational from the current
// state and instruction fields; write strobes are forced low during reset.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       illegal_instr,
    output logic       instr_done
);

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    pc_write_c, ir_write_c, mem_write_c, reg_write_c, illegal_c, done_c;

    // State register; reset abandons whatever instruction is in flight
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and per-state control outputs; anything not set stays 0
    always_comb begin
        state_d     = state_q;
        alu_op      = ALUOP_ADD;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        done_c      = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECUTER;
                    OP_IMM:            state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                        done_c    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                done_c      = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_SUB;
                case (funct3)
                    3'b000:  pc_write_c = zero;
                    3'b001:  pc_write_c = ~zero;
                    default: pc_write_c = 1'b0;
                endcase
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JAL;
            end
            S_JAL: begin
                // PC <- target held in alu_out while the ALU forms old_pc+4 for rd
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        case (op)
            OP_LOAD, OP_JALR, OP_IMM: imm_src = IMM_I;
            OP_STORE:                 imm_src = IMM_S;
            OP_BRANCH:                imm_src = IMM_B;
            OP_JAL:                   imm_src = IMM_J;
            OP_LUI, OP_AUIPC:         imm_src = IMM_U;
            default:                  imm_src = 3'b000;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alu_control(alu_control)
    );

    assign pc_write      = pc_write_c  & ~reset;
    assign ir_write      = ir_write_c  & ~reset;
    assign mem_write     = mem_write_c & ~reset;
    assign reg_write     = reg_write_c & ~reset;
    assign illegal_instr = illegal_c   & ~reset;
    assign instr_done    = done_c      & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into the
// per-cycle output script the controller must produce, then compared every cycle.
module tb_multicycle_controller;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                           A_XOR = 4'd4, A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7,
                           A_SRL = 4'd8, A_SRA = 4'd9;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
                           BAD = 7'b1111111;

    typedef struct packed {
        logic       pcw, adr, irw, memw, regw;
        logic [1:0] res, sa, sb;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       ill, done;
    } exp_t;
    typedef struct { exp_t e; logic mr; } cyc_t;

    logic clk, reset, funct7b5, zero, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic pc_write, adr_src, ir_write, mem_write, reg_write, illegal_instr, instr_done;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;

    int tests = 0, fails = 0;
    exp_t exp_q[$];
    cyc_t plan[$];
    logic [2:0] cur_imm;
    exp_t ce, cg;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control),
        .illegal_instr(illegal_instr), .instr_done(instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_imm(input logic [6:0] o);
        case (o)
            LW, JR, IT: return 3'b000;
            SW:         return 3'b001;
            BR:         return 3'b010;
            JL:         return 3'b011;
            LU, AU:     return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'd0: return (is_r && f7) ? A_SUB : A_ADD;
            3'd1: return A_SLL;
            3'd2: return A_SLT;
            3'd3: return A_SLTU;
            3'd4: return A_XOR;
            3'd5: return f7 ? A_SRA : A_SRL;
            3'd6: return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic mr, pcw, adr, irw, memw, regw,
                       input logic [1:0] res, sa, sb, input logic [3:0] alu,
                       input logic ill, done);
        cyc_t c;
        c.mr = mr;
        c.e = '{pcw:pcw, adr:adr, irw:irw, memw:memw, regw:regw, res:res, sa:sa,
                sb:sb, alu:alu, imm:cur_imm, ill:ill, done:done};
        plan.push_back(c);
    endtask

    task automatic add_wb();
        add(rbit(), 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, A_ADD, 0, 1);
    endtask

    // Expand one instruction into its cycle script (nf fetch stalls, nm memory stalls)
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int nf, input int nm);
        logic legal;
        plan.delete();
        cur_imm = ref_imm(o);
        legal = (o inside {LW, SW, RT, IT, BR, JL, JR, LU, AU});
        repeat (nf) add(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, A_ADD, 0, 0);
        add(1, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, A_ADD, 0, 0);
        add(rbit(), 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, A_ADD, !legal, !legal);
        case (o)
            LW: begin
                add(rbit(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, A_ADD, 0, 0);
                repeat (nm) add(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 0);
                add(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 0);
                add(rbit(), 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, A_ADD, 0, 1);
            end
            SW: begin
                add(rbit(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, A_ADD, 0, 0);
                repeat (nm) add(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 0);
                add(1, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, A_ADD, 0, 1);
            end
            RT: begin
                add(rbit(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ref_alu(f3, f7, 1), 0, 0);
                add_wb();
            end
            IT: begin
                add(rbit(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ref_alu(f3, f7, 0), 0, 0);
                add_wb();
            end
            BR: add(rbit(), (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0,
                    0, 0, 0, 0, 2'b00, 2'b10, 2'b00, A_SUB, 0, 1);
            JL, JR: begin
                if (o == JR) add(rbit(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, A_ADD, 0, 0);
                add(rbit(), 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, A_ADD, 0, 0);
                add_wb();
            end
            LU: begin
                add(rbit(), 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, A_ADD, 0, 0);
                add_wb();
            end
            AU: begin
                add(rbit(), 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, A_ADD, 0, 0);
                add_wb();
            end
            default: ;
        endcase
    endtask

    // Drive the first n cycles of the current script; expectations go to the checker
    task automatic run_plan(input int n);
        for (int i = 0; i < n && i < plan.size(); i++) begin
            mem_ready = plan[i].mr;
            exp_q.push_back(plan[i].e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int nf, input int nm);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        build(o, f3, f7, z, nf, nm);
        run_plan(plan.size());
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, want);
        end
    endtask

    // Per-cycle compare of all outputs against the expected script
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            cg = '{pcw:pc_write, adr:adr_src, irw:ir_write, memw:mem_write,
                   regw:reg_write, res:result_src, sa:alu_src_a, sb:alu_src_b,
                   alu:alu_control, imm:imm_src, ill:illegal_instr, done:instr_done};
            tests++;
            if (cg !== ce) begin
                fails++;
                $display("FAIL cycle t=%0t op=%b got=%h exp=%h", $time, op, cg, ce);
            end
        end
    end

    initial begin
        logic [6:0] ops [10];
        ops = '{LW, SW, RT, IT, BR, JL, JR, LU, AU, BAD};
        reset = 1'b1; mem_ready = 1'b1; op = IT; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;

        // Model latencies with mem_ready=1, and branch decisions
        build(LW, 0, 0, 0, 0, 0); chk("lat_lw", plan.size(), 5);
        build(SW, 0, 0, 0, 0, 0); chk("lat_sw", plan.size(), 4);
        build(RT, 0, 0, 0, 0, 0); chk("lat_r", plan.size(), 4);
        build(BR, 0, 0, 0, 0, 0); chk("lat_br", plan.size(), 3);
        build(JL, 0, 0, 0, 0, 0); chk("lat_jal", plan.size(), 4);
        build(JR, 0, 0, 0, 0, 0); chk("lat_jalr", plan.size(), 5);
        build(LW, 0, 0, 0, 0, 3); chk("lat_lw_stall3", plan.size(), 8);
        build(BR, 3'd0, 0, 1, 0, 0); chk("beq_taken_model", plan[2].e.pcw, 1);
        build(BR, 3'd1, 0, 1, 0, 0); chk("bne_nottaken_model", plan[2].e.pcw, 0);

        // Two reset cycles: strobes held low even with mem_ready=1
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_pc_write", pc_write, 0);
            chk("rst_ir_write", ir_write, 0);
        end
        reset = 1'b0; op = IT;
        #1;
        chk("post_rst_ir_write", ir_write, 1);
        chk("post_rst_pc_write", pc_write, 1);

        // addi, add, lw, sw, branches, stalled lw, jalr, illegal
        issue(IT, 3'd0, 1, 0, 0, 0);
        issue(RT, 3'd0, 0, 0, 0, 0);
        issue(LW, 3'd2, 0, 0, 0, 0);
        issue(SW, 3'd2, 0, 0, 0, 0);
        issue(BR, 3'd0, 0, 1, 0, 0);
        issue(BR, 3'd1, 0, 1, 0, 0);
        issue(LW, 3'd2, 0, 0, 0, 3);
        issue(JR, 3'd0, 0, 0, 0, 0);
        issue(BAD, 3'd0, 0, 0, 0, 0);

        // Randomized instruction stream with fetch/memory stalls
        for (int k = 0; k < 400; k++) begin
            logic [6:0] o;
            o = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            issue(o, 3'($urandom), rbit(), rbit(), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset during a store stall: mem_write drops at once, FETCH next edge
        op = SW; funct3 = 3'd2; funct7b5 = 0; zero = 0;
        build(SW, 3'd2, 0, 0, 0, 5);
        run_plan(4);
        mem_ready = 1'b0;
        #1;
        chk("sw_stall_mem_write", mem_write, 1);
        reset = 1'b1;
        #1;
        chk("rst_stall_mem_write", mem_write, 0);
        chk("rst_stall_done", instr_done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_fetch_adr_src", adr_src, 0);
        chk("rst_fetch_src_b", alu_src_b, 2'b10);
        chk("rst_fetch_result", result_src, 2'b10);
        chk("rst_fetch_pc_write", pc_write, 0);
        issue(IT, 3'd5, 1, 0, 1, 0);

        @(posedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
